// File: rtl/tcp_opt_pkg.sv
// Shared TCP option definitions: kind/length constants and option FSM encoding.
// Used by both the option encoder and the option decoder.
package tcp_opt_pkg;

  localparam logic [7:0] KIND_EOL   = 8'd0;
  localparam logic [7:0] KIND_NOP   = 8'd1;
  localparam logic [7:0] KIND_MSS   = 8'd2;
  localparam logic [7:0] KIND_WS    = 8'd3;
  localparam logic [7:0] KIND_SACKP = 8'd4;
  localparam logic [7:0] KIND_SACK  = 8'd5;
  localparam logic [7:0] KIND_TS    = 8'd8;

  localparam logic [7:0] LEN_MSS      = 8'd4;
  localparam logic [7:0] LEN_WS       = 8'd3;
  localparam logic [7:0] LEN_SACKP    = 8'd2;
  localparam logic [7:0] LEN_TS       = 8'd10;
  localparam logic [7:0] LEN_SACK_HDR = 8'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MSS,
    ST_TS_HDR,
    ST_TSVAL,
    ST_TSECR,
    ST_SACKP,
    ST_WS,
    ST_SACK_HDR,
    ST_SACK_L,
    ST_SACK_R,
    ST_DONE
  } opt_state_e;

  // SACK option length byte: 2 header bytes plus 8 per block.
  function automatic logic [7:0] sack_len(input logic [2:0] n);
    return LEN_SACK_HDR + {2'b00, n, 3'b000};
  endfunction

endpackage

// File: rtl/tcp_option_len_calc.sv
// Combinational option-area sizing: SACK block count that fits, total length
// in words, and whether the requested SACK count had to be reduced.
module tcp_option_len_calc #(
  parameter int unsigned MAX_OPT_WORDS = 10,
  parameter int unsigned MAX_SACK      = 4
) (
  input  logic       mss_en,
  input  logic       ws_en,
  input  logic       sackp_en,
  input  logic       ts_en,
  input  logic [2:0] sack_nbr,
  output logic [2:0] n,
  output logic [3:0] opt_words,
  output logic       sack_trunc
);

  logic [2:0] other;
  logic [2:0] req;
  logic [2:0] room;

  always_comb begin
    other = {2'b00, mss_en} + {2'b00, ws_en}
          + (ts_en ? 3'd3 : (sackp_en ? 3'd1 : 3'd0));
    req   = (sack_nbr > 3'(MAX_SACK)) ? 3'(MAX_SACK) : sack_nbr;
    // One word goes to the SACK header, each block needs two.
    room  = ({1'b0, other} >= 4'(MAX_OPT_WORDS)) ? 3'd0
          : 3'((4'(MAX_OPT_WORDS) - 4'd1 - {1'b0, other}) >> 1);
    n          = (req < room) ? req : room;
    sack_trunc = (n < req);
    opt_words  = {1'b0, other} + ((n != 3'd0) ? {n, 1'b1} : 4'd0);
  end

endmodule

// File: rtl/tcp_option_encoder.sv
// TCP option serialiser: captures option fields on start and streams them as
// word-aligned, NOP-padded 32-bit words with a valid/ready handshake.
module tcp_option_encoder
  import tcp_opt_pkg::*;
#(
  parameter int unsigned MAX_OPT_WORDS = 10,
  parameter int unsigned MAX_SACK      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mss_en,
  input  logic [15:0] mss,
  input  logic        wscale_en,
  input  logic [7:0]  scale_wnd,
  input  logic        sackp_en,
  input  logic [2:0]  sack_nbr,
  input  logic [63:0] sack_n0,
  input  logic [63:0] sack_n1,
  input  logic [63:0] sack_n2,
  input  logic [63:0] sack_n3,
  input  logic        ts_en,
  input  logic [63:0] time_stp,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  opt_words,
  output logic        sack_trunc,
  output logic        busy,
  output logic        done
);

  opt_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        n_q, n_d;
  logic              mss_en_q, mss_en_d, ws_en_q, ws_en_d;
  logic              sackp_en_q, sackp_en_d, ts_en_q, ts_en_d;
  logic [15:0]       mss_q, mss_d;
  logic [7:0]        scale_q, scale_d;
  logic [63:0]       ts_q, ts_d;
  logic [3:0][63:0]  sack_q, sack_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [3:0]        opt_words_q, opt_words_d;
  logic              sack_trunc_q, sack_trunc_d, busy_q, busy_d, done_q, done_d;

  logic [2:0]        calc_n;
  logic [3:0]        calc_words;
  logic              calc_trunc;
  logic [31:0]       word;
  opt_state_e        nxt;

  tcp_option_len_calc #(
    .MAX_OPT_WORDS(MAX_OPT_WORDS),
    .MAX_SACK     (MAX_SACK)
  ) u_len_calc (
    .mss_en    (mss_en),
    .ws_en     (wscale_en),
    .sackp_en  (sackp_en),
    .ts_en     (ts_en),
    .sack_nbr  (sack_nbr),
    .n         (calc_n),
    .opt_words (calc_words),
    .sack_trunc(calc_trunc)
  );

  // Next word-producing state after s; disabled options fall through by enum order.
  function automatic opt_state_e next_state(input opt_state_e s, input logic m, input logic t,
                                            input logic sp, input logic w,
                                            input logic [2:0] n, input logic [1:0] idx);
    opt_state_e r;
    if (s < ST_MSS && m)                                  r = ST_MSS;
    else if (s < ST_TS_HDR && t)                          r = ST_TS_HDR;
    else if (s == ST_TS_HDR)                              r = ST_TSVAL;
    else if (s == ST_TSVAL)                               r = ST_TSECR;
    else if (s < ST_SACKP && sp && !t)                    r = ST_SACKP;
    else if (s < ST_WS && w)                              r = ST_WS;
    else if (s < ST_SACK_HDR && n != 3'd0)                r = ST_SACK_HDR;
    else if (s == ST_SACK_HDR)                            r = ST_SACK_L;
    else if (s == ST_SACK_L)                              r = ST_SACK_R;
    else if (s == ST_SACK_R && {1'b0, idx} != n - 3'd1)   r = ST_SACK_L;
    else                                                  r = ST_DONE;
    return r;
  endfunction

  always_comb begin
    word = '0;
    unique case (state_q)
      ST_MSS:      word = {KIND_MSS, LEN_MSS, mss_q};
      ST_TS_HDR:   word = sackp_en_q ? {KIND_SACKP, LEN_SACKP, KIND_TS, LEN_TS}
                                     : {KIND_NOP, KIND_NOP, KIND_TS, LEN_TS};
      ST_TSVAL:    word = ts_q[63:32];
      ST_TSECR:    word = ts_q[31:0];
      ST_SACKP:    word = {KIND_NOP, KIND_NOP, KIND_SACKP, LEN_SACKP};
      ST_WS:       word = {KIND_NOP, KIND_WS, LEN_WS, scale_q};
      ST_SACK_HDR: word = {KIND_NOP, KIND_NOP, KIND_SACK, sack_len(n_q)};
      ST_SACK_L:   word = sack_q[idx_q][63:32];
      ST_SACK_R:   word = sack_q[idx_q][31:0];
      default:     word = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    mss_en_d     = mss_en_q;
    ws_en_d      = ws_en_q;
    sackp_en_d   = sackp_en_q;
    ts_en_d      = ts_en_q;
    mss_d        = mss_q;
    scale_d      = scale_q;
    ts_d         = ts_q;
    sack_d       = sack_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    opt_words_d  = opt_words_q;
    sack_trunc_d = sack_trunc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    nxt          = next_state(state_q, mss_en_q, ts_en_q, sackp_en_q, ws_en_q, n_q, idx_q);

    if (state_q == ST_IDLE) begin
      if (start) begin
        mss_en_d     = mss_en;
        ws_en_d      = wscale_en;
        sackp_en_d   = sackp_en;
        ts_en_d      = ts_en;
        mss_d        = mss;
        scale_d      = scale_wnd;
        ts_d         = time_stp;
        sack_d       = {sack_n3, sack_n2, sack_n1, sack_n0};
        n_d          = calc_n;
        opt_words_d  = calc_words;
        sack_trunc_d = calc_trunc;
        idx_d        = 2'd0;
        busy_d       = 1'b1;
        state_d      = next_state(ST_IDLE, mss_en, ts_en, sackp_en, wscale_en, calc_n, 2'd0);
      end
    end else if (!out_valid_q || out_ready) begin
      // Output slot is free: either load the word for state_q or, in DONE, retire.
      if (state_q == ST_DONE) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end else begin
        out_data_d  = word;
        out_valid_d = 1'b1;
        out_last_d  = (nxt == ST_DONE);
        state_d     = nxt;
        if (state_q == ST_SACK_R) idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      mss_en_q     <= 1'b0;
      ws_en_q      <= 1'b0;
      sackp_en_q   <= 1'b0;
      ts_en_q      <= 1'b0;
      mss_q        <= '0;
      scale_q      <= '0;
      ts_q         <= '0;
      sack_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      opt_words_q  <= '0;
      sack_trunc_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      mss_en_q     <= mss_en_d;
      ws_en_q      <= ws_en_d;
      sackp_en_q   <= sackp_en_d;
      ts_en_q      <= ts_en_d;
      mss_q        <= mss_d;
      scale_q      <= scale_d;
      ts_q         <= ts_d;
      sack_q       <= sack_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      opt_words_q  <= opt_words_d;
      sack_trunc_q <= sack_trunc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign opt_words  = opt_words_q;
  assign sack_trunc = sack_trunc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
